pio_keys_poller: RTL and testbench



---
 rtl/pio_keys_poller.sv | 151 +++++++++++++++
 tb/tb_pio_keys_poller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_keys_poller.sv
// Avalon-MM master that periodically reads and clears the key PIO edge-capture
// register, then reads key levels; presses are delivered as valid/ready events.
module pio_keys_poller #(
    parameter int unsigned POLL_CYCLES  = 50000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned KEY_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 poll_enable,
    output logic [1:0]           avm_address,
    output logic                 avm_chipselect,
    output logic                 avm_write_n,
    output logic [31:0]          avm_writedata,
    input  logic [31:0]          avm_readdata,
    output logic                 event_valid,
    input  logic                 event_ready,
    output logic [KEY_WIDTH-1:0] event_keys,
    output logic                 event_overflow,
    input  logic                 overflow_clear,
    output logic [KEY_WIDTH-1:0] key_level
);

    localparam int unsigned CNT_W  = $clog2(POLL_CYCLES);
    localparam int unsigned WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0]  POLL_LAST = CNT_W'(POLL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_EDGE,
        WAIT_EDGE,
        CLR_EDGE,
        RD_LEVEL,
        WAIT_LEVEL
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    poll_cnt, poll_cnt_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
    logic [KEY_WIDTH-1:0] edges;
    logic                capture;
    logic                level_load;
    logic                accept;
    logic                unused_readdata;

    assign edges           = avm_readdata[KEY_WIDTH-1:0];
    assign unused_readdata = ^avm_readdata[31:KEY_WIDTH];
    assign avm_writedata   = '0;
    assign accept          = event_valid & event_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            poll_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            poll_cnt <= poll_cnt_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        poll_cnt_next  = poll_cnt;
        wait_cnt_next  = '0;
        capture        = 1'b0;
        level_load     = 1'b0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = 2'd0;
        case (state)
            IDLE: begin
                if (poll_enable) begin
                    if (poll_cnt == POLL_LAST) begin
                        poll_cnt_next = '0;
                        state_next    = RD_EDGE;
                    end else begin
                        poll_cnt_next = poll_cnt + 1'b1;
                    end
                end
            end
            RD_EDGE: begin
                avm_chipselect = 1'b1;
                avm_address    = 2'd3;
                state_next     = WAIT_EDGE;
            end
            WAIT_EDGE: begin
                if (wait_cnt == WAIT_LAST) begin
                    capture    = (edges != '0);
                    state_next = (edges != '0) ? CLR_EDGE : RD_LEVEL;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            CLR_EDGE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 2'd3;
                state_next     = RD_LEVEL;
            end
            RD_LEVEL: begin
                avm_chipselect = 1'b1;
                state_next     = WAIT_LEVEL;
            end
            WAIT_LEVEL: begin
                if (wait_cnt == WAIT_LAST) begin
                    level_load = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A capture in the same cycle as an accept starts a fresh event rather than merging.
    always_ff @(posedge clk) begin
        if (reset) begin
            event_valid    <= 1'b0;
            event_keys     <= '0;
            event_overflow <= 1'b0;
            key_level      <= '0;
        end else begin
            if (capture) begin
                event_valid <= 1'b1;
                if (!event_valid || accept) begin
                    event_keys <= edges;
                end else begin
                    event_keys <= event_keys | edges;
                end
            end else if (accept) begin
                event_valid <= 1'b0;
                event_keys  <= '0;
            end

            if (capture && event_valid && !accept && ((event_keys & edges) != '0)) begin
                event_overflow <= 1'b1;
            end else if (overflow_clear) begin
                event_overflow <= 1'b0;
            end

            if (level_load) begin
                key_level <= avm_readdata[KEY_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pio_keys_poller.sv
// Directed bench: behavioural key PIO slave, bus-cycle monitor and an event scoreboard.
module tb_pio_keys_poller;

    logic        clk = 1'b0;
    logic        reset;
    logic        poll_enable;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'hA5A5_A5A5;
    logic        event_valid;
    logic        event_ready;
    logic [3:0]  event_keys;
    logic        event_overflow;
    logic        overflow_clear;
    logic [3:0]  key_level;

    logic [3:0]  keys      = '0;
    logic [3:0]  keys_prev = '0;
    logic [3:0]  edge_cap  = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rd3 = 0, n_wr3 = 0, n_rd0 = 0, n_wd_bad = 0;
    int s_rd3, s_wr3, s_rd0;
    logic [3:0] sb[$];

    pio_keys_poller #(
        .POLL_CYCLES (8),
        .READ_LATENCY(1),
        .KEY_WIDTH   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .poll_enable   (poll_enable),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_keys    (event_keys),
        .event_overflow(event_overflow),
        .overflow_clear(overflow_clear),
        .key_level     (key_level)
    );

    always #5 clk = ~clk;

    // Slave: rising-edge capture cleared by any write to address 3, read latency 1,
    // junk on readdata whenever no read is in flight.
    always @(posedge clk) begin
        keys_prev <= keys;
        if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
            edge_cap <= '0;
        else
            edge_cap <= edge_cap | (keys & ~keys_prev);
        if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 2'd3) ? {28'd0, edge_cap} : {28'd0, keys};
        else
            avm_readdata <= 32'hA5A5_A5A5;
    end

    always @(negedge clk) begin
        if (avm_chipselect) begin
            if (!avm_write_n && avm_address == 2'd3) n_wr3++;
            else if (avm_write_n && avm_address == 2'd3) n_rd3++;
            else if (avm_write_n && avm_address == 2'd0) n_rd0++;
        end
        if (avm_writedata != 32'd0) n_wd_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_rd3 = n_rd3;
        s_wr3 = n_wr3;
        s_rd0 = n_rd0;
    endtask

    task automatic wait_bus(input logic [1:0] a, input logic wn, input string tag);
        logic found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (avm_chipselect && avm_write_n == wn && avm_address == a) found = 1'b1;
        end
        check({tag, "_seen"}, {31'd0, found}, 32'd1);
    endtask

    // Ends two cycles after RD_LEVEL: back in IDLE with key_level loaded.
    task automatic wait_done(input string tag);
        wait_bus(2'd0, 1'b1, tag);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input string tag);
        logic [3:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, "_keys"}, {28'd0, event_keys}, {28'd0, exp});
            check({tag, "_valid"}, {31'd0, event_valid}, 32'd1);
            event_ready = 1'b1;
            @(negedge clk);
            event_ready = 1'b0;
            check({tag, "_valid_drop"}, {31'd0, event_valid}, 32'd0);
            check({tag, "_keys_drop"}, {28'd0, event_keys}, 32'd0);
        end
    endtask

    task automatic press(input int unsigned bit_idx);
        keys[bit_idx] = 1'b1;
    endtask

    initial begin
        int k;
        reset          = 1'b1;
        poll_enable    = 1'b0;
        event_ready    = 1'b0;
        overflow_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs", {31'd0, avm_chipselect}, 32'd0);
        check("rst_wn", {31'd0, avm_write_n}, 32'd1);
        check("rst_addr", {30'd0, avm_address}, 32'd0);
        check("rst_valid", {31'd0, event_valid}, 32'd0);
        check("rst_keys", {28'd0, event_keys}, 32'd0);
        check("rst_ovf", {31'd0, event_overflow}, 32'd0);
        check("rst_level", {28'd0, key_level}, 32'd0);
        reset = 1'b0;

        // Polling disabled: bus stays silent
        repeat (2000) @(negedge clk);
        check("idle_bus", n_rd3 + n_wr3 + n_rd0, 32'd0);
        check("idle_valid", {31'd0, event_valid}, 32'd0);

        // First RD_EDGE exactly POLL_CYCLES cycles after enabling
        snap();
        poll_enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!avm_chipselect && k < 50);
        check("first_rd_edge_cycle", k, 32'd8);
        check("first_rd_edge_addr", {30'd0, avm_address}, 32'd3);

        // No press: read/read, no write, no event
        wait_done("nopress");
        check("nopress_rd3", n_rd3 - s_rd3, 32'd1);
        check("nopress_wr3", n_wr3 - s_wr3, 32'd0);
        check("nopress_rd0", n_rd0 - s_rd0, 32'd1);
        check("nopress_valid", {31'd0, event_valid}, 32'd0);

        // Period after a short sequence: counting restarts from 0 in IDLE
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!avm_chipselect && k < 50);
        check("period", k, 32'd8);
        wait_done("period_seq");

        // Single press of key 2
        snap();
        press(2);
        sb.push_back(4'b0100);
        wait_done("single");
        check("single_rd3", n_rd3 - s_rd3, 32'd1);
        check("single_wr3", n_wr3 - s_wr3, 32'd1);
        check("single_rd0", n_rd0 - s_rd0, 32'd1);
        check("single_level", {28'd0, key_level}, 32'h4);
        repeat (3) @(negedge clk);
        check("single_hold", {31'd0, event_valid}, 32'd1);
        accept("single_acc");

        // Merge and overflow with no consumer
        press(0);
        wait_done("merge_a");
        check("merge_a_keys", {28'd0, event_keys}, 32'h1);
        press(1);
        sb.push_back(4'b0011);
        wait_done("merge_b");
        check("merge_b_keys", {28'd0, event_keys}, 32'h3);
        check("merge_b_ovf", {31'd0, event_overflow}, 32'd0);
        keys[0] = 1'b0;
        @(negedge clk);
        press(0);
        wait_done("merge_c");
        check("merge_c_ovf", {31'd0, event_overflow}, 32'd1);
        check("merge_c_keys", {28'd0, event_keys}, 32'h3);
        overflow_clear = 1'b1;
        @(negedge clk);
        overflow_clear = 1'b0;
        check("ovf_cleared", {31'd0, event_overflow}, 32'd0);
        accept("merge_acc");

        // Accept and new capture on the same edge
        keys = 4'b0000;
        @(negedge clk);
        press(0);
        wait_done("simul_a");
        check("simul_a_keys", {28'd0, event_keys}, 32'h1);
        press(3);
        wait_bus(2'd3, 1'b1, "simul_rd_edge");
        @(negedge clk);
        event_ready = 1'b1;
        @(negedge clk);
        event_ready = 1'b0;
        check("simul_keys", {28'd0, event_keys}, 32'h8);
        check("simul_valid", {31'd0, event_valid}, 32'd1);
        check("simul_ovf", {31'd0, event_overflow}, 32'd0);
        sb.push_back(4'b1000);
        wait_done("simul_b");
        accept("simul_acc");

        // Reset during WAIT_EDGE drops the pending event but not the slave capture
        press(2);
        @(negedge clk);
        keys[2] = 1'b0;
        @(negedge clk);
        press(2);
        wait_done("pre_reset");
        check("pre_reset_valid", {31'd0, event_valid}, 32'd1);
        snap();
        press(1);
        wait_bus(2'd3, 1'b1, "rst_rd_edge");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_cs", {31'd0, avm_chipselect}, 32'd0);
        check("midrst_valid", {31'd0, event_valid}, 32'd0);
        check("midrst_keys", {28'd0, event_keys}, 32'd0);
        check("midrst_level", {28'd0, key_level}, 32'd0);
        check("midrst_slave_cap", {28'd0, edge_cap}, 32'h2);
        check("midrst_no_write", n_wr3 - s_wr3, 32'd0);
        sb.push_back(4'b0010);
        wait_done("post_reset");
        check("post_reset_wr3", n_wr3 - s_wr3, 32'd1);
        check("post_reset_level", {28'd0, key_level}, 32'hF);
        accept("post_reset_acc");

        check("writedata_zero", n_wd_bad, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
